// File: rtl/spi_ram_burst.sv
// SPI-slave-to-RAM bridge: command-framed serial access to an on-chip single-port RAM,
// with optional auto-increment bursts, address wrap, range checking and abort detection.
module spi_ram_burst #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter bit BURST_EN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic err
);

  localparam int SW_RAW = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
  localparam int SW     = (SW_RAW > 2) ? SW_RAW : 2;
  localparam int CW     = $clog2(SW + 1);
  localparam int AW1    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0]         CNT_ZERO      = CW'(0);
  localparam logic [CW-1:0]         CNT_ONE       = CW'(1);
  localparam logic [CW-1:0]         ADDR_LAST_CNT = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0]         DATA_LAST_CNT = CW'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO     = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [AW1-1:0]        DEPTH_L       = AW1'(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    WDATA = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [CW-1:0]           cnt_r;
  logic [SW-1:0]           shift_r;
  logic [SW-1:0]           shift_in_s;
  logic                    done_r;
  logic                    is_rd_r;
  logic [ADDR_WIDTH-1:0]   wr_addr_r;
  logic [ADDR_WIDTH-1:0]   rd_addr_r;
  logic [ADDR_WIDTH-1:0]   addr_in_s;
  logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word_s;
  logic [DATA_WIDTH-1:0]   wdata_s;
  logic                    miso_r;
  logic                    err_r;
  logic                    miso_next_s;
  logic                    err_next_s;
  logic                    active_s;
  logic                    abort_s;
  logic                    addr_last_s;
  logic                    addr_ok_s;
  logic                    wr_last_s;
  logic                    rd_active_s;
  logic                    rd_last_s;

  // Wrap at the real memory depth, which need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (a == LAST_ADDR) begin
      return ADDR_ZERO;
    end else begin
      return a + ADDR_ONE;
    end
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!SS_n) begin
          state_next_s = CMD;
        end else begin
          state_next_s = IDLE;
        end
      end
      CMD: begin
        if (SS_n) begin
          state_next_s = IDLE;
        end else if (cnt_r == CNT_ONE) begin
          case ({shift_r[0], MOSI})
            2'b01:   state_next_s = WDATA;
            2'b11:   state_next_s = RDATA;
            default: state_next_s = ADDR;
          endcase
        end else begin
          state_next_s = CMD;
        end
      end
      ADDR, WDATA, RDATA: begin
        if (SS_n) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output and datapath control decode
  always_comb begin
    shift_in_s  = {shift_r[SW-2:0], MOSI};
    addr_in_s   = shift_in_s[ADDR_WIDTH-1:0];
    wdata_s     = shift_in_s[DATA_WIDTH-1:0];
    rd_word_s   = mem_r[rd_addr_r];
    active_s    = !SS_n && !done_r;
    // A partially received read word is not an error, hence RDATA is excluded.
    abort_s     = SS_n && (state_r inside {CMD, ADDR, WDATA}) && (cnt_r != CNT_ZERO);
    addr_last_s = active_s && (state_r == ADDR) && (cnt_r == ADDR_LAST_CNT);
    addr_ok_s   = ({1'b0, addr_in_s} < DEPTH_L);
    wr_last_s   = active_s && (state_r == WDATA) && (cnt_r == DATA_LAST_CNT);
    rd_active_s = active_s && (state_r == RDATA);
    rd_last_s   = rd_active_s && (cnt_r == DATA_LAST_CNT);
    err_next_s  = abort_s || (addr_last_s && !addr_ok_s);
    if (rd_active_s) begin
      if (cnt_r == CNT_ZERO) begin
        miso_next_s = rd_word_s[DATA_WIDTH-1];
      end else begin
        miso_next_s = shift_r[DATA_WIDTH-1];
      end
    end else begin
      miso_next_s = 1'b0;
    end
  end

  // Counters, shift register, address latches and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= CNT_ZERO;
      shift_r   <= '0;
      done_r    <= 1'b0;
      is_rd_r   <= 1'b0;
      wr_addr_r <= ADDR_ZERO;
      rd_addr_r <= ADDR_ZERO;
      miso_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      miso_r <= miso_next_s;
      err_r  <= err_next_s;
      if (SS_n || (state_r == IDLE)) begin
        cnt_r   <= CNT_ZERO;
        shift_r <= '0;
        done_r  <= 1'b0;
      end else begin
        case (state_r)
          CMD: begin
            if (cnt_r == CNT_ONE) begin
              cnt_r   <= CNT_ZERO;
              shift_r <= '0;
              is_rd_r <= shift_r[0];
            end else begin
              cnt_r   <= cnt_r + CNT_ONE;
              shift_r <= shift_in_s;
            end
          end
          ADDR: begin
            if (!done_r) begin
              shift_r <= shift_in_s;
              if (addr_last_s) begin
                cnt_r  <= CNT_ZERO;
                done_r <= 1'b1;
                if (addr_ok_s) begin
                  if (is_rd_r) begin
                    rd_addr_r <= addr_in_s;
                  end else begin
                    wr_addr_r <= addr_in_s;
                  end
                end
              end else begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end
          end
          WDATA: begin
            if (!done_r) begin
              shift_r <= shift_in_s;
              if (wr_last_s) begin
                cnt_r <= CNT_ZERO;
                if (BURST_EN) begin
                  wr_addr_r <= next_addr(wr_addr_r);
                end else begin
                  done_r <= 1'b1;
                end
              end else begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end
          end
          RDATA: begin
            if (!done_r) begin
              // The first bit goes out straight from RAM; the rest from the shifter.
              if (cnt_r == CNT_ZERO) begin
                shift_r <= SW'(rd_word_s) << 1;
              end else begin
                shift_r <= shift_r << 1;
              end
              if (rd_last_s) begin
                cnt_r <= CNT_ZERO;
                if (BURST_EN) begin
                  rd_addr_r <= next_addr(rd_addr_r);
                end else begin
                  done_r <= 1'b1;
                end
              end else begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end
          end
          default: begin
            cnt_r <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_last_s) begin
      mem_r[wr_addr_r] <= wdata_s;
    end
  end

  assign MISO = miso_r;
  assign err  = err_r;
  assign busy = (state_r != IDLE);

endmodule
